// File: rtl/simple_processor_pkg.sv
// Shared types for the logic-op datapath and its scheduler.
package simple_processor_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ALU_AND = 2'd0,
    ALU_OR  = 2'd1,
    ALU_XOR = 2'd2,
    ALU_NOT = 2'd3
  } alu_func_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } alu_sched_state_t;

endpackage

// File: rtl/alu_gate.sv
// Combinational bitwise logic unit; NOT ignores operand b.
module alu_gate
  import simple_processor_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_func_t        func,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (func)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_NOT: y = ~a;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found              = 1'b1;
        gnt[IDX_W'(idx)]   = 1'b1;
        gnt_idx            = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_gate_sched.sv
// Shares one alu_gate between NUM_REQ requesters, one registered operation at a time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | arbitrating; the granted request is accepted this cycle
// ST_BUSY | result held in res_q until the owner takes the response
module alu_gate_sched
  import simple_processor_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = simple_processor_pkg::DATA_WIDTH
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_rs1_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_rs2_i,
  input  alu_func_t [NUM_REQ-1:0]             req_func_i,
  output logic [NUM_REQ-1:0]                  rsp_valid_o,
  input  logic [NUM_REQ-1:0]                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0]               rsp_data_o,
  output logic                                busy_o,
  output logic [31:0]                         op_count_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  alu_sched_state_t      state_q;
  logic [IDX_W-1:0]      prio_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [DATA_WIDTH-1:0] res_q;
  logic [31:0]           cnt_q;

  logic [NUM_REQ-1:0]    gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      prio_next;
  logic [DATA_WIDTH-1:0] alu_y;
  logic                  rsp_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid_i),
    .ptr     (prio_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  alu_gate #(.WIDTH(DATA_WIDTH)) u_alu (
    .a    (req_rs1_i[gnt_idx]),
    .b    (req_rs2_i[gnt_idx]),
    .func (req_func_i[gnt_idx]),
    .y    (alu_y)
  );

  // Reset gates the grant so no requester sees a handshake while held in reset.
  assign req_ready_o = (rst_ni && state_q == ST_IDLE) ? gnt : '0;
  assign prio_next   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  // rsp_valid_q is one-hot on the owner, so it doubles as the owner record.
  assign rsp_done    = |(rsp_valid_q & rsp_ready_i);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      prio_q      <= '0;
      rsp_valid_q <= '0;
      res_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|gnt) begin
            res_q       <= alu_y;
            rsp_valid_q <= gnt;
            prio_q      <= prio_next;
            state_q     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (rsp_done) begin
            rsp_valid_q <= '0;
            res_q       <= '0;
            cnt_q       <= cnt_q + 32'd1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = res_q;
  assign busy_o      = (state_q == ST_BUSY);
  assign op_count_o  = cnt_q;

endmodule

// File: tb/tb_alu_gate_sched.sv
// Directed and randomized checks of alu_gate_sched with two requesters.
module tb_alu_gate_sched;
  import simple_processor_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][31:0]      rs1;
  logic [1:0][31:0]      rs2;
  alu_func_t [1:0]       func;
  logic [1:0]            rsp_valid;
  logic [1:0]            rsp_ready;
  logic [31:0]           rsp_data;
  logic                  busy;
  logic [31:0]           op_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;

  alu_gate_sched #(.NUM_REQ(2), .DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_rs1_i   (rs1),
    .req_rs2_i   (rs2),
    .req_func_i  (func),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy),
    .op_count_o  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [31:0] a;
    logic [31:0] b;
    alu_func_t   f;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input alu_func_t f);
    case (f)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic do_op(input vec_t v);
    logic [1:0] oh;
    oh = 2'b01 << v.r;
    req_valid  = oh;
    rs1[v.r]   = v.a;
    rs2[v.r]   = v.b;
    func[v.r]  = v.f;
    rsp_ready  = oh;
    #1;
    chk("vec_ready", 64'(req_ready), 64'(oh));
    step();
    req_valid = 2'b00;
    chk("vec_rsp_valid", 64'(rsp_valid), 64'(oh));
    chk("vec_data", 64'(rsp_data), 64'(v.exp));
    step();
    exp_cnt++;
    chk("vec_count", 64'(op_count), 64'(exp_cnt));
    chk("vec_idle_data", 64'(rsp_data), 64'd0);
  endtask

  initial begin
    logic [1:0] exp_g;
    int         tally [2];
    int         d;

    vecs[0] = '{0, 32'hF0F0_00FF, 32'h0FF0_0F0F, ALU_XOR, 32'hFF00_0FF0};
    vecs[1] = '{1, 32'hFFFF_0000, 32'h1234_5678, ALU_AND, 32'h1234_0000};
    vecs[2] = '{0, 32'hA5A5_0000, 32'h0000_5A5A, ALU_OR,  32'hA5A5_5A5A};
    vecs[3] = '{1, 32'h0000_FFFF, 32'hDEAD_BEEF, ALU_NOT, 32'hFFFF_0000};
    vecs[4] = '{0, 32'h0000_0000, 32'hFFFF_FFFF, ALU_AND, 32'h0000_0000};
    vecs[5] = '{1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ALU_XOR, 32'h0000_0000};
    vecs[6] = '{0, 32'hFFFF_FFFF, 32'h0000_1234, ALU_NOT, 32'h0000_0000};
    vecs[7] = '{1, 32'h8000_0001, 32'h7FFF_FFFE, ALU_OR,  32'hFFFF_FFFF};

    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b00;
    rs1       = '0;
    rs2       = '0;
    func      = '{ALU_AND, ALU_AND};

    // Reset held for three cycles with both requesters valid
    repeat (3) step();
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_data", 64'(rsp_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(op_count), 64'd0);

    // Release: req0 wins first and performs the XOR
    rst_n     = 1'b1;
    rs1[0]    = 32'hF0F0_00FF;
    rs2[0]    = 32'h0FF0_0F0F;
    func[0]   = ALU_XOR;
    rsp_ready = 2'b11;
    #1;
    chk("first_grant", 64'(req_ready), 64'h1);
    step();
    chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("single_data", 64'(rsp_data), 64'hFF00_0FF0);
    chk("single_busy", 64'(busy), 64'd1);
    chk("single_ready_low", 64'(req_ready), 64'd0);
    step();
    exp_cnt = 1;
    chk("single_count", 64'(op_count), 64'd1);

    // Fairness: both valid, responses taken immediately; pointer now at 1
    exp_g = 2'b10;
    tally = '{0, 0};
    for (int i = 0; i < 8; i++) begin
      chk("rr_grant", 64'(req_ready), 64'(exp_g));
      if (req_ready == 2'b01) tally[0]++;
      if (req_ready == 2'b10) tally[1]++;
      step();
      chk("rr_rsp_valid", 64'(rsp_valid), 64'(exp_g));
      step();
      exp_cnt++;
      exp_g = ~exp_g;
    end
    chk("rr_tally0", 64'(tally[0]), 64'd4);
    chk("rr_tally1", 64'(tally[1]), 64'd4);
    chk("rr_count", 64'(op_count), 64'd9);

    // Backpressure: req1 NOT held five cycles, req0 waiting
    rs1[1]    = 32'h0000_FFFF;
    func[1]   = ALU_NOT;
    rsp_ready = 2'b01;
    #1;
    chk("bp_grant1", 64'(req_ready), 64'h2);
    step();
    req_valid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      chk("bp_data", 64'(rsp_data), 64'hFFFF_0000);
      chk("bp_busy", 64'(busy), 64'd1);
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      chk("bp_rsp_valid", 64'(rsp_valid), 64'h2);
      step();
    end
    chk("bp_count_hold", 64'(op_count), 64'(exp_cnt));
    rsp_ready = 2'b11;
    step();
    exp_cnt++;
    chk("bp_count", 64'(op_count), 64'(exp_cnt));
    chk("bp_grant0_next", 64'(req_ready), 64'h1);

    // Wrong-owner ready: req0 pending, only rsp_ready[1] asserted
    rsp_ready = 2'b10;
    step();
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      chk("wo_busy", 64'(busy), 64'd1);
      chk("wo_count", 64'(op_count), 64'(exp_cnt));
      step();
    end

    // Reset while the result is pending
    rst_n     = 1'b0;
    req_valid = 2'b01;
    step();
    chk("rmid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rmid_count", 64'(op_count), 64'd0);
    chk("rmid_busy", 64'(busy), 64'd0);
    chk("rmid_ready", 64'(req_ready), 64'd0);
    rst_n     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rmid_no_rsp", 64'(rsp_valid), 64'd0);
    end
    chk("rmid_count_after", 64'(op_count), 64'd0);
    exp_cnt = 0;

    // Random sweep: both valid every op, 1000 grants each, random response delay
    exp_g = 2'b01;
    tally = '{0, 0};
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] e;
      int          g;
      for (int r = 0; r < 2; r++) begin
        rs1[r]  = $urandom;
        rs2[r]  = $urandom;
        func[r] = alu_func_t'($urandom_range(0, 3));
      end
      g = (exp_g == 2'b01) ? 0 : 1;
      e = ref_alu(rs1[g], rs2[g], func[g]);
      req_valid = 2'b11;
      rsp_ready = 2'b00;
      #1;
      chk("sw_grant", 64'(req_ready), 64'(exp_g));
      step();
      tally[g]++;
      d = $urandom_range(0, 2);
      repeat (d) step();
      chk("sw_data", 64'(rsp_data), 64'(e));
      rsp_ready = 2'b11;
      step();
      exp_cnt++;
      exp_g = ~exp_g;
    end
    chk("sw_tally0", 64'(tally[0]), 64'd1000);
    chk("sw_tally1", 64'(tally[1]), 64'd1000);
    chk("sw_count", 64'(op_count), 64'(exp_cnt));

    // Table of directed single-requester vectors
    for (int i = 0; i < 8; i++) do_op(vecs[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
